// File: rtl/system_sequencer_pkg.sv
// Shared definitions for the system sequencer: state encoding, ternary word geometry
// and PC constants.
package system_sequencer_pkg;

    localparam int TRIT_W = 2;
    localparam int TRITS  = 9;
    localparam int WORD_W = TRIT_W * TRITS;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOADING   = 2'd1,
        ST_EXECUTING = 2'd2,
        ST_HALTED    = 2'd3
    } seq_state_t;

    localparam logic [TRIT_W-1:0] TRIT_NEG  = 2'b10;
    localparam logic [TRIT_W-1:0] TRIT_ZERO = 2'b00;
    localparam logic [TRIT_W-1:0] TRIT_POS  = 2'b01;

    // 2'b11 is not a legal trit, so an all-ones PC can never be fetched.
    localparam logic [WORD_W-1:0] INVALID_PC = {WORD_W{1'b1}};

endpackage

// File: rtl/system_sequencer_halt_detect.sv
// Halt detector: tracks the last fetched PC and counts consecutive identical fetches,
// pulsing halt on the fetch that makes the count reach HALT_REPEAT.
module seq_halt_detect
    import system_sequencer_pkg::*;
#(
    parameter int HALT_REPEAT = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              init,
    input  logic              active,
    input  logic              fetch,
    input  logic [WORD_W-1:0] pc,
    output logic              halt
);

    localparam int CNT_W = $clog2(HALT_REPEAT + 1);
    localparam logic [CNT_W-1:0] REPEAT_MAX  = CNT_W'(HALT_REPEAT);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(HALT_REPEAT - 1);

    logic [WORD_W-1:0] last_pc_reg, last_pc_next;
    logic [CNT_W-1:0]  repeat_cnt_reg, repeat_cnt_next;
    logic              pc_match;

    assign pc_match = (pc == last_pc_reg);

    always_comb begin
        last_pc_next    = last_pc_reg;
        repeat_cnt_next = repeat_cnt_reg;
        halt            = 1'b0;
        if (init) begin
            last_pc_next    = INVALID_PC;
            repeat_cnt_next = '0;
        end else if (active && fetch) begin
            if (pc_match) begin
                if (repeat_cnt_reg < REPEAT_MAX) begin
                    repeat_cnt_next = repeat_cnt_reg + 1'b1;
                end
                halt = (repeat_cnt_reg >= REPEAT_LAST);
            end else begin
                last_pc_next    = pc;
                repeat_cnt_next = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            last_pc_reg    <= INVALID_PC;
            repeat_cnt_reg <= '0;
        end else begin
            last_pc_reg    <= last_pc_next;
            repeat_cnt_reg <= repeat_cnt_next;
        end
    end

endmodule

// File: rtl/system_sequencer.sv
// System sequencer: IDLE -> LOADING -> EXECUTING -> HALTED control with a single
// arbitrated memory port. Optional watchdog built when SYSTEM_WATCHDOG_EN is defined.
module system_sequencer
    import system_sequencer_pkg::*;
#(
    parameter int HALT_REPEAT    = 5,
    parameter int WATCHDOG_LIMIT = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        load_done,
    input  logic        load_mem_write,
    input  logic [17:0] load_addr,
    input  logic [17:0] load_data,
    input  logic        cpu_mem_write,
    input  logic [17:0] cpu_addr,
    input  logic [17:0] cpu_wdata,
    input  logic [17:0] cpu_pc,
    input  logic        cpu_fetch,
    output logic        loader_go,
    output logic        cpu_run,
    output logic        mem_write,
    output logic [17:0] mem_addr,
    output logic [17:0] mem_wdata,
    output logic [1:0]  system_state,
    output logic        timeout,
    output logic        conflict
);

    seq_state_t state_reg, state_next;
    logic       loader_go_reg, loader_go_next;
    logic       timeout_reg, timeout_next;
    logic       conflict_reg, conflict_next;
    logic       enter_exec;
    logic       halt;
    logic       wd_expire;

    assign enter_exec = (state_reg == ST_LOADING) && load_done;

    seq_halt_detect #(
        .HALT_REPEAT (HALT_REPEAT)
    ) u_halt_detect (
        .clock  (clock),
        .reset  (reset),
        .init   (enter_exec),
        .active (state_reg == ST_EXECUTING),
        .fetch  (cpu_fetch),
        .pc     (cpu_pc),
        .halt   (halt)
    );

`ifdef SYSTEM_WATCHDOG_EN
    localparam logic [15:0] WDOG_LAST = 16'(WATCHDOG_LIMIT - 1);
    logic [15:0] wdog_cnt_reg;

    always_ff @(posedge clock) begin
        if (!reset || enter_exec) begin
            wdog_cnt_reg <= '0;
        end else if (state_reg == ST_EXECUTING) begin
            wdog_cnt_reg <= wdog_cnt_reg + 16'd1;
        end
    end

    // The counter holds k during the (k+1)th executing cycle, so expiring at
    // LIMIT-1 gives exactly WATCHDOG_LIMIT executing cycles.
    assign wd_expire = (state_reg == ST_EXECUTING) && (wdog_cnt_reg >= WDOG_LAST);
`else
    logic unused_wdog_limit;
    assign unused_wdog_limit = (WATCHDOG_LIMIT == 0);
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        loader_go_next = 1'b0;
        timeout_next   = timeout_reg;
        conflict_next  = conflict_reg;
        cpu_run        = 1'b0;
        mem_write      = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        case (state_reg)
            ST_IDLE: begin
                if (load_mem_write || cpu_mem_write) conflict_next = 1'b1;
                if (start) begin
                    state_next     = ST_LOADING;
                    loader_go_next = 1'b1;
                end
            end
            ST_LOADING: begin
                mem_write = load_mem_write;
                mem_addr  = load_addr;
                mem_wdata = load_data;
                if (cpu_mem_write) conflict_next = 1'b1;
                if (load_done) state_next = ST_EXECUTING;
            end
            ST_EXECUTING: begin
                cpu_run   = 1'b1;
                mem_write = cpu_mem_write;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                if (load_mem_write) conflict_next = 1'b1;
                if (halt || wd_expire) state_next = ST_HALTED;
                if (wd_expire) timeout_next = 1'b1;
            end
            ST_HALTED: begin
                if (load_mem_write || cpu_mem_write) conflict_next = 1'b1;
                // A restart clears both flags, even against a write in the same cycle.
                if (start) begin
                    state_next     = ST_LOADING;
                    loader_go_next = 1'b1;
                    timeout_next   = 1'b0;
                    conflict_next  = 1'b0;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            loader_go_reg <= 1'b0;
            timeout_reg   <= 1'b0;
            conflict_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            loader_go_reg <= loader_go_next;
            timeout_reg   <= timeout_next;
            conflict_reg  <= conflict_next;
        end
    end

    assign loader_go    = loader_go_reg;
    assign system_state = state_reg;
    assign timeout      = timeout_reg;
    assign conflict     = conflict_reg;

endmodule

// File: tb/tb_system_sequencer.sv
// Directed bench for system_sequencer; covers load, halt detect, watchdog (when
// SYSTEM_WATCHDOG_EN is defined), arbitration drops and reset aborts.
module tb_system_sequencer;

`ifdef SYSTEM_WATCHDOG_EN
    localparam int WDL = 20;
`else
    localparam int WDL = 1000;
`endif

    logic        clock = 1'b0;
    logic        reset, start, load_done, load_mem_write, cpu_mem_write, cpu_fetch;
    logic [17:0] load_addr, load_data, cpu_addr, cpu_wdata, cpu_pc;
    logic        loader_go, cpu_run, mem_write, timeout, conflict;
    logic [17:0] mem_addr, mem_wdata;
    logic [1:0]  system_state;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    system_sequencer #(
        .HALT_REPEAT    (5),
        .WATCHDOG_LIMIT (WDL)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .load_done      (load_done),
        .load_mem_write (load_mem_write),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .cpu_mem_write  (cpu_mem_write),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_pc         (cpu_pc),
        .cpu_fetch      (cpu_fetch),
        .loader_go      (loader_go),
        .cpu_run        (cpu_run),
        .mem_write      (mem_write),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .system_state   (system_state),
        .timeout        (timeout),
        .conflict       (conflict)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input logic [17:0] pc);
        cpu_pc    = pc;
        cpu_fetch = 1'b1;
        tick();
        cpu_fetch = 1'b0;
        $display("fetch pc=%0d -> state=%0d run=%0d", pc, system_state, cpu_run);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; load_done = 1'b0;
        load_mem_write = 1'b0; load_addr = '0; load_data = '0;
        cpu_mem_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        cpu_pc = '0; cpu_fetch = 1'b0;
        tick(); tick();
        reset = 1'b1;
        check("rst_state", system_state, 0);
        check("rst_run", cpu_run, 0);
        check("rst_go", loader_go, 0);
        check("rst_timeout", timeout, 0);
        check("rst_conflict", conflict, 0);
        check("rst_memw", mem_write, 0);
        check("rst_repeat", dut.u_halt_detect.repeat_cnt_reg, 0);

        // load_done outside LOADING is ignored
        load_done = 1'b1; tick(); load_done = 1'b0;
        check("idle_ld_done", system_state, 0);

        start = 1'b1; tick(); start = 1'b0;
        $display("start -> state=%0d go=%0d", system_state, loader_go);
        check("start_state", system_state, 1);
        check("start_go", loader_go, 1);
        tick();
        check("go_one_cycle", loader_go, 0);
        check("load_hold", system_state, 1);

        for (int i = 0; i < 4; i++) begin
            load_mem_write = 1'b1;
            load_addr      = 18'(i);
            load_data      = 18'h100 + 18'(i);
            cpu_mem_write  = (i == 2);
            cpu_addr       = 18'h3ffff;
            cpu_wdata      = 18'h3ffff;
            #1;
            check("load_memw", mem_write, 1);
            check("load_addr", mem_addr, i);
            check("load_data", mem_wdata, 32'h100 + i);
            check("load_run", cpu_run, 0);
            tick();
            $display("load write addr=%0d conflict=%0d", i, conflict);
        end
        load_mem_write = 1'b0; cpu_mem_write = 1'b0;
        check("load_conflict", conflict, 1);

        // load_done beats a simultaneous start
        start = 1'b1; load_done = 1'b1; tick(); start = 1'b0; load_done = 1'b0;
        check("exec_state", system_state, 2);
        check("exec_run", cpu_run, 1);
        check("exec_go", loader_go, 0);

        cpu_mem_write = 1'b1; cpu_addr = 18'h155; cpu_wdata = 18'h2aa;
        load_mem_write = 1'b1; load_addr = 18'd5; load_data = 18'd6;
        #1;
        check("cpu_memw", mem_write, 1);
        check("cpu_addr", mem_addr, 32'h155);
        check("cpu_wdata", mem_wdata, 32'h2aa);
        cpu_mem_write = 1'b0; load_mem_write = 1'b0;

        fetch(18'd7);
        for (int i = 0; i < 4; i++) fetch(18'd7);
        check("rep4_state", system_state, 2);
        check("rep4_cnt", dut.u_halt_detect.repeat_cnt_reg, 4);
        fetch(18'd9);
        check("change_clear", dut.u_halt_detect.repeat_cnt_reg, 0);
        for (int i = 0; i < 4; i++) fetch(18'd9);
        check("rep4b_state", system_state, 2);
        check("rep4b_cnt", dut.u_halt_detect.repeat_cnt_reg, 4);

        fetch(18'd0); fetch(18'd1); fetch(18'd2);
        for (int i = 0; i < 4; i++) fetch(18'd2);
        check("pre_halt", system_state, 2);
        fetch(18'd2);
        check("halt_state", system_state, 3);
        check("halt_run", cpu_run, 0);
        check("halt_cnt", dut.u_halt_detect.repeat_cnt_reg, 5);
        check("halt_timeout", timeout, 0);

        cpu_mem_write = 1'b1; cpu_addr = 18'd9; cpu_wdata = 18'd9;
        #1;
        check("halted_memw", mem_write, 0);
        check("halted_addr", mem_addr, 0);
        tick(); cpu_mem_write = 1'b0;
        check("halted_conflict", conflict, 1);

        start = 1'b1; tick(); start = 1'b0;
        check("reload_state", system_state, 1);
        check("reload_go", loader_go, 1);
        check("reload_conflict", conflict, 0);
        check("reload_timeout", timeout, 0);
        load_done = 1'b1; tick(); load_done = 1'b0;
        check("reexec_state", system_state, 2);

        for (int i = 0; i < 19; i++) fetch(18'(100 + i));
        check("wd_pre", system_state, 2);
        fetch(18'd200);
`ifdef SYSTEM_WATCHDOG_EN
        check("wd_state", system_state, 3);
        check("wd_timeout", timeout, 1);
        start = 1'b1; tick(); start = 1'b0;
        load_done = 1'b1; tick(); load_done = 1'b0;
        check("wd_restart", system_state, 2);
        check("wd_restart_to", timeout, 0);
`else
        for (int i = 0; i < 80; i++) fetch(18'(300 + i));
        check("nowd_state", system_state, 2);
        check("nowd_timeout", timeout, 0);
`endif

        // reset mid-EXECUTING with writes pending on both sides
        cpu_mem_write = 1'b1; load_mem_write = 1'b1; reset = 1'b0;
        tick();
        check("rstx_state", system_state, 0);
        check("rstx_run", cpu_run, 0);
        check("rstx_memw", mem_write, 0);
        check("rstx_conflict", conflict, 0);
        cpu_mem_write = 1'b0; load_mem_write = 1'b0; reset = 1'b1;

        start = 1'b1; tick(); start = 1'b0;
        check("rstl_pre", system_state, 1);
        load_mem_write = 1'b1; reset = 1'b0;
        tick();
        check("rstl_state", system_state, 0);
        check("rstl_memw", mem_write, 0);
        reset = 1'b1; load_mem_write = 1'b0;

        cpu_mem_write = 1'b1;
        #1;
        check("idle_memw", mem_write, 0);
        tick(); cpu_mem_write = 1'b0;
        check("idle_conflict", conflict, 1);
        check("idle_state", system_state, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
